// File: rtl/ub_skew_reader_if.sv
// Bundles the request, buffer read-port and skewed output signals of ub_skew_reader.
// The slave modport is the reader itself. The master modport is its environment.
interface ub_skew_reader_if #(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                          start;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic [ADDR_WIDTH:0]           row_count;
    logic                          busy;
    logic                          done;
    logic                          enb;
    logic [ADDR_WIDTH-1:0]         addrb;
    logic [LANES*DATA_WIDTH-1:0]   doutb;
    logic [LANES*DATA_WIDTH-1:0]   data_out;
    logic [LANES-1:0]              valid_out;

    modport master (
        output start, base_addr, row_count, doutb,
        input  busy, done, enb, addrb, data_out, valid_out
    );

    modport slave (
        input  start, base_addr, row_count, doutb,
        output busy, done, enb, addrb, data_out, valid_out
    );
endinterface

// File: rtl/ub_skew_reader.sv
// Streams a block of buffer rows and re-times them into a diagonal wavefront.
// Lane j of every row reaches the array j cycles after lane 0.
module ub_skew_reader #(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    ub_skew_reader_if.slave bus
);
    localparam int CW  = ADDR_WIDTH + 1;
    localparam int DCW = $clog2(LANES + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic                  enb_q, enb_next;
    logic [CW-1:0]         remaining, remaining_next;
    logic [DCW-1:0]        drain_cnt, drain_next;
    logic                  rd_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            enb_q     <= 1'b0;
            remaining <= '0;
            drain_cnt <= '0;
            rd_tag    <= 1'b0;
        end else begin
            state     <= state_next;
            addr_q    <= addr_next;
            enb_q     <= enb_next;
            remaining <= remaining_next;
            drain_cnt <= drain_next;
            rd_tag    <= enb_q;
        end
    end

    // remaining counts the rows still to issue after the one currently on addrb
    always_comb begin
        state_next     = state;
        addr_next      = addr_q;
        enb_next       = 1'b0;
        remaining_next = remaining;
        drain_next     = drain_cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.row_count == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next     = READ;
                        enb_next       = 1'b1;
                        addr_next      = bus.base_addr;
                        remaining_next = bus.row_count - CW'(1);
                    end
                end
            end
            READ: begin
                if (remaining == '0) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end else begin
                    enb_next       = 1'b1;
                    addr_next      = addr_q + ADDR_WIDTH'(1);
                    remaining_next = remaining - CW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DCW'(LANES)) begin
                    state_next = DONE;
                end else begin
                    drain_next = drain_cnt + DCW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy  = (state == READ) || (state == DRAIN);
    assign bus.done  = (state == DONE);
    assign bus.enb   = enb_q;
    assign bus.addrb = addr_q;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int D = j + 1;
        localparam int W = D * DATA_WIDTH;

        // Oldest element sits in the top slice of dly and the top bit of vld
        logic [W-1:0] dly;
        logic [D-1:0] vld;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dly <= '0;
                vld <= '0;
            end else begin
                dly <= (dly << DATA_WIDTH) | W'(bus.doutb[j*DATA_WIDTH +: DATA_WIDTH]);
                vld <= (vld << 1) | D'(rd_tag);
            end
        end

        assign bus.valid_out[j] = vld[D-1];
        assign bus.data_out[j*DATA_WIDTH +: DATA_WIDTH] = vld[D-1] ? dly[W-1 -: DATA_WIDTH] : '0;
    end
endmodule

// File: tb/tb_ub_skew_reader.sv
// Bench for ub_skew_reader: table vectors, hand-written corner sequences, random transfers.
// A cycle-level reference model derived from the timing rules checks every output each cycle.
module tb_ub_skew_reader;
    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int VW    = 3 + AW + LANES + LANES * DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ub_skew_reader_if #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ub_skew_reader #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [LANES*DW-1:0] mem [256];

    // One-cycle-latency buffer read port
    always @(posedge clk) begin
        if (bus.enb) bus.doutb <= mem[bus.addrb];
    end

    int tests_run = 0;
    int tests_failed = 0;
    int first_done;
    logic signed [DW-1:0] cap0 [300];
    logic signed [DW-1:0] cap15 [300];
    logic [AW-1:0] capaddr [300];

    typedef struct {
        int base;
        int count;
        int pulse;
        int exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic reportCompare(input string name, input int c, input logic [VW-1:0] act,
                                 input logic [VW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s cycle %0d {busy,done,enb,addr,valid,data}: got %h expected %h",
                     name, c, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int c, input int base, input int n);
        logic [LANES*DW-1:0] ed;
        logic [LANES-1:0]    ev;
        logic                eb, edn, ee;
        logic [AW-1:0]       ea;
        int                  r;
        ed  = '0;
        ev  = '0;
        eb  = (n != 0) && (c >= 1) && (c <= n + 17);
        edn = (n == 0) ? (c == 1) : (c == n + 18);
        ee  = (c >= 1) && (c <= n);
        ea  = ee ? AW'(base + c - 1) : '0;
        for (int j = 0; j < LANES; j++) begin
            r = c - 3 - j;
            if (r >= 0 && r < n) begin
                ev[j] = 1'b1;
                ed[j*DW +: DW] = mem[(base + r) % 256][j*DW +: DW];
            end
        end
        reportCompare(name, c,
                      {bus.busy, bus.done, bus.enb, (ee ? bus.addrb : AW'(0)), bus.valid_out, bus.data_out},
                      {eb, edn, ee, ea, ev, ed});
    endtask

    // Starts one transfer and checks cycles 1..n+19; optionally re-pulses start mid-transfer
    task automatic applyStimulus(input string name, input int base, input int n, input int pulse);
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.row_count = (AW+1)'(n);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.row_count = (AW+1)'($urandom);
        first_done = 0;
        for (int c = 1; c <= n + 19; c++) begin
            if (c == pulse) begin
                bus.start     = 1'b1;
                bus.base_addr = AW'(100);
                bus.row_count = (AW+1)'($urandom_range(1, 256));
            end else begin
                bus.start = 1'b0;
            end
            checkOutput(name, c, base, n);
            if (bus.done && first_done == 0) first_done = c;
            if (c < 300) begin
                cap0[c]    = bus.data_out[DW-1:0];
                cap15[c]   = bus.data_out[LANES*DW-1 -: DW];
                capaddr[c] = bus.addrb;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic fillPattern();
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < LANES; j++)
                mem[i][j*DW +: DW] = DW'(i / 2 - j);
    endtask

    initial begin
        int lane0_exp [4];
        int lane15_exp [4];
        int wrap_exp [4];
        int done_count;
        int base, n, pulse;

        lane0_exp  = '{0, 1, 1, 2};
        lane15_exp = '{-15, -14, -14, -13};
        wrap_exp   = '{254, 255, 0, 1};

        vecs[0] = '{base: 1,   count: 4,   pulse: 0, exp_done: 22};
        vecs[1] = '{base: 254, count: 4,   pulse: 0, exp_done: 22};
        vecs[2] = '{base: 0,   count: 0,   pulse: 0, exp_done: 1};
        vecs[3] = '{base: 0,   count: 256, pulse: 0, exp_done: 274};
        vecs[4] = '{base: 30,  count: 6,   pulse: 5, exp_done: 24};
        vecs[5] = '{base: 255, count: 1,   pulse: 0, exp_done: 19};

        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.row_count = '0;
        bus.doutb     = '0;
        fillPattern();

        #1;
        reportCompare("reset_state", 0,
                      {bus.busy, bus.done, bus.enb, bus.addrb, bus.valid_out, bus.data_out}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].base, vecs[i].count, vecs[i].pulse);
            checkInt($sformatf("vec%0d_done_cycle", i), first_done, vecs[i].exp_done);
            if (i == 0) begin
                for (int k = 0; k < 4; k++) begin
                    checkInt($sformatf("plan_addr_c%0d", k + 1), int'(capaddr[k + 1]), k + 1);
                    checkInt($sformatf("plan_lane0_c%0d", k + 3), int'(cap0[k + 3]), lane0_exp[k]);
                    checkInt($sformatf("plan_lane15_c%0d", k + 18), int'(cap15[k + 18]), lane15_exp[k]);
                end
            end
            if (i == 1) begin
                for (int k = 0; k < 4; k++)
                    checkInt($sformatf("wrap_addr_c%0d", k + 1), int'(capaddr[k + 1]), wrap_exp[k]);
            end
        end

        // Reset asserted part-way through an N=10 transfer
        bus.start     = 1'b1;
        bus.base_addr = AW'(20);
        bus.row_count = (AW+1)'(10);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checkOutput("pre_reset", c, 20, 10);
            if (c < 8) begin
                @(posedge clk);
                #1;
            end
        end
        #2 reset_n = 1'b0;
        #1;
        reportCompare("async_reset", 8,
                      {bus.busy, bus.done, bus.enb, bus.addrb, bus.valid_out, bus.data_out}, '0);
        @(posedge clk);
        #1;
        reportCompare("reset_hold", 9,
                      {bus.busy, bus.done, bus.enb, bus.addrb, bus.valid_out, bus.data_out}, '0);
        @(negedge clk) reset_n = 1'b1;
        done_count = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_count++;
        end
        checkInt("no_done_after_reset", done_count, 0);
        applyStimulus("after_reset", 20, 10, 0);
        checkInt("after_reset_done_cycle", first_done, 28);

        // Random transfers over random buffer contents
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = {$urandom, $urandom, $urandom, $urandom};
            base  = $urandom_range(0, 255);
            n     = $urandom_range(1, 40);
            pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n + 17) : 0;
            applyStimulus($sformatf("rand%0d", k), base, n, pulse);
            checkInt($sformatf("rand%0d_done_cycle", k), first_done, n + 18);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
